stack_arbiter: RTL

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_pkg.sv | 13 +
 rtl/stack_arbiter_stack.sv | 56 +++++
 rtl/stack_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter: FSM state encoding and operation codes.
package stack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arbiter_stack.sv
// Team LIFO stack: Push/Pop sampled on the rising edge, Data_Out holds the
// most recently popped value from the edge after the pop.
module stack_arbiter_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] Data_In,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Full,
  output logic              Empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CW-1:0]     count_q, count_d, count_m1;
  logic [DATA_W-1:0] dout_q, dout_d;

  assign Full     = (count_q == CW'(DEPTH));
  assign Empty    = (count_q == '0);
  assign count_m1 = count_q - CW'(1);
  assign Data_Out = dout_q;

  // Illegal strobes (push when full, pop when empty) are ignored here as a backstop.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (Push && !Full) begin
      mem_d[count_q[AW-1:0]] = Data_In;
      count_d                = count_q + CW'(1);
    end else if (Pop && !Empty) begin
      dout_d  = mem_q[count_m1[AW-1:0]];
      count_d = count_m1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Two-client round-robin front end for the team stack. Each request runs
// IDLE -> ISSUE -> RESP, with a registered one-cycle Ack/Err/Dout response.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              Req0,
  input  logic              Op0,
  input  logic [DATA_W-1:0] Din0,
  output logic              Ack0,
  output logic              Err0,
  output logic [DATA_W-1:0] Dout0,
  input  logic              Req1,
  input  logic              Op1,
  input  logic [DATA_W-1:0] Din1,
  output logic              Ack1,
  output logic              Err1,
  output logic [DATA_W-1:0] Dout1,
  output logic              Full,
  output logic              Empty
);

  // Handshake: a client holds Req high until it sees its one-cycle Ack;
  // Err/Dout are meaningful only while that Ack is high.
  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic              push, pop;
  logic [DATA_W-1:0] data_in, data_out;
  logic              req0_eff, req1_eff, pick;

  stack_arbiter_stack #(.DATA_W(DATA_W)) u_stack (
    .Clk      (Clk),
    .RstN     (RstN),
    .Push     (push),
    .Pop      (pop),
    .Data_In  (data_in),
    .Data_Out (data_out),
    .Full     (Full),
    .Empty    (Empty)
  );

  // A client still showing its Ack has not yet had the chance to drop Req.
  assign req0_eff = Req0 && !ack0_q;
  assign req1_eff = Req1 && !ack1_q;
  assign pick     = (req0_eff && req1_eff) ? !last_q : req1_eff;
  assign data_in  = din_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    op_d    = op_q;
    din_d   = din_q;
    err_d   = err_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    dout0_d = '0;
    dout1_d = '0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_eff || req1_eff) begin
          id_d    = pick;
          op_d    = pick ? Op1 : Op0;
          din_d   = pick ? Din1 : Din0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        err_d   = (op_q == OP_PUSH) ? Full : Empty;
        push    = (op_q == OP_PUSH) && !Full;
        pop     = (op_q == OP_POP) && !Empty;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (id_q) begin
          ack1_d  = 1'b1;
          err1_d  = err_q;
          dout1_d = (op_q == OP_POP && !err_q) ? data_out : '0;
        end else begin
          ack0_d  = 1'b1;
          err0_d  = err_q;
          dout0_d = (op_q == OP_POP && !err_q) ? data_out : '0;
        end
        last_d  = id_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      op_q    <= OP_POP;
      din_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      din_q   <= din_d;
      err_q   <= err_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  assign Ack0  = ack0_q;
  assign Ack1  = ack1_q;
  assign Err0  = err0_q;
  assign Err1  = err1_q;
  assign Dout0 = dout0_q;
  assign Dout1 = dout1_q;

endmodule
